// File: rtl/charset_pkg.sv
// Purpose: shared geometry and types for the writable character-set table.
//   CHAR_W : bits per character
//   DEPTH  : maximum number of table entries (>= 2, power of 2 not required)
//   IDX_W  : index width, derived from DEPTH
//   LEN_W  : length width, derived from DEPTH (must hold the value DEPTH)
// The table geometry lives here so the top, the read lanes and the bench agree on it.
package charset_pkg;

    localparam int CHAR_W = 7;
    localparam int DEPTH  = 64;
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int LEN_W  = $clog2(DEPTH + 1);

    typedef logic [CHAR_W-1:0] char_t;
    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [LEN_W-1:0]  len_t;

    // One registered read result: char, odometer successor, carry-out and out-of-range.
    typedef struct packed {
        char_t ch;
        idx_t  nxt;
        logic  wrap;
        logic  oor;
    } rd_lane_t;

    // Value a lane holds after reset: an empty table reads as "carry out".
    localparam rd_lane_t LANE_RESET = '{
        ch:   {CHAR_W{1'b0}},
        nxt:  {IDX_W{1'b0}},
        wrap: 1'b1,
        oor:  1'b0
    };

endpackage

// File: rtl/charset_rd_lane.sv
// Purpose: one registered read lane of the character-set table.
//   clk, reset_n : clock, asynchronous active-low reset
//   rd_en_i      : sample this lane on the next edge
//   ord_i        : index to look up
//   len_i        : current number of valid entries (value before the edge)
//   mem_i        : table storage, owned by the top
//   lane_o       : registered char / successor / wrap / out-of-range
// With rd_en_i low the lane holds its previous result.
module charset_rd_lane
    import charset_pkg::*;
(
    input  logic     clk,
    input  logic     reset_n,
    input  logic     rd_en_i,
    input  idx_t     ord_i,
    input  len_t     len_i,
    input  char_t    mem_i [DEPTH],
    output rd_lane_t lane_o
);

    len_t     ord_ext_s;
    len_t     ord_inc_s;
    logic     oor_s;
    logic     wrap_s;
    rd_lane_t lane_d;
    rd_lane_t lane_q;

    // ord+1 is formed at length width so it never overflows (max value DEPTH).
    assign ord_ext_s = len_t'(ord_i);
    assign ord_inc_s = ord_ext_s + len_t'(1'b1);
    // wrap covers len==0 naturally: ord+1 >= 0 always holds.
    assign oor_s     = (ord_ext_s >= len_i);
    assign wrap_s    = (ord_inc_s >= len_i);

    // Next lane result: lookup plus successor arithmetic when sampling, else hold.
    always_comb begin
        lane_d = lane_q;
        if (rd_en_i) begin
            lane_d.oor  = oor_s;
            lane_d.wrap = wrap_s;
            if (wrap_s) begin
                lane_d.nxt = {IDX_W{1'b0}};
            end else begin
                // Not wrapping implies ord+1 < len <= DEPTH, so the truncation is lossless.
                lane_d.nxt = idx_t'(ord_inc_s);
            end
            if (oor_s) begin
                lane_d.ch = {CHAR_W{1'b0}};
            end else begin
                lane_d.ch = mem_i[ord_i];
            end
        end else begin
            lane_d = lane_q;
        end
    end

    // Lane result register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane_q <= LANE_RESET;
        end else begin
            lane_q <= lane_d;
        end
    end

    assign lane_o = lane_q;

endmodule

// File: rtl/charset_table_mp.sv
// Purpose: writable character-set table with NUM_RD registered read lanes.
//   Host side : clear, lock, w_en, w_char -> w_ready, len, full, err_ovf
//   Read side : rd_en, rd_ord (lane i at [i*IDX_W +: IDX_W])
//               -> rd_valid, rd_char, rd_next, rd_wrap, rd_oor (one cycle later)
// The host appends characters at index len; clear empties the table and wins
// over a same-cycle write. Lanes evaluate against len as it stood before the
// edge, so an entry written in the same cycle reads as out of range.
module charset_table_mp
    import charset_pkg::*;
#(
    parameter int NUM_RD = 4
)
(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     lock,
    input  logic                     w_en,
    input  logic [CHAR_W-1:0]        w_char,
    output logic                     w_ready,
    output logic [LEN_W-1:0]         len,
    output logic                     full,
    output logic                     err_ovf,
    input  logic                     rd_en,
    input  logic [NUM_RD*IDX_W-1:0]  rd_ord,
    output logic                     rd_valid,
    output logic [NUM_RD*CHAR_W-1:0] rd_char,
    output logic [NUM_RD*IDX_W-1:0]  rd_next,
    output logic [NUM_RD-1:0]        rd_wrap,
    output logic [NUM_RD-1:0]        rd_oor
);

    char_t mem_q [DEPTH];
    len_t  len_q;
    len_t  len_d;
    logic  err_q;
    logic  err_d;
    logic  valid_q;
    logic  full_s;
    logic  wr_fire_s;

    assign full_s    = (len_q == len_t'(DEPTH));
    assign w_ready   = !full_s && !lock;
    assign wr_fire_s = w_en && w_ready && !clear;

    // Length and sticky overflow next state; clear discards a same-cycle write silently.
    always_comb begin
        len_d = len_q;
        err_d = err_q;
        if (clear) begin
            len_d = {LEN_W{1'b0}};
            err_d = 1'b0;
        end else if (w_en) begin
            if (w_ready) begin
                len_d = len_q + len_t'(1'b1);
            end else begin
                err_d = 1'b1;
            end
        end else begin
            len_d = len_q;
        end
    end

    // Control state: length, overflow flag, read-valid pipeline bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_q   <= {LEN_W{1'b0}};
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            len_q   <= len_d;
            err_q   <= err_d;
            valid_q <= rd_en;
        end
    end

    // Table storage, intentionally unreset; w_ready guarantees len_q < DEPTH here.
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            mem_q[len_q[IDX_W-1:0]] <= w_char;
        end
    end

    assign len      = len_q;
    assign full     = full_s;
    assign err_ovf  = err_q;
    assign rd_valid = valid_q;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_lane
        rd_lane_t lane_s;

        charset_rd_lane u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .rd_en_i (rd_en),
            .ord_i   (rd_ord[g*IDX_W +: IDX_W]),
            .len_i   (len_q),
            .mem_i   (mem_q),
            .lane_o  (lane_s)
        );

        assign rd_char[g*CHAR_W +: CHAR_W] = lane_s.ch;
        assign rd_next[g*IDX_W +: IDX_W]   = lane_s.nxt;
        assign rd_wrap[g]                  = lane_s.wrap;
        assign rd_oor[g]                   = lane_s.oor;
    end

endmodule

// File: tb/tb_charset_table_mp.sv
// Self-checking bench for charset_table_mp: directed scenarios plus a
// randomized run checked against a queue-based model of the table.
module tb_charset_table_mp;
    import charset_pkg::*;

    localparam int NRD = 4;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   clear = 1'b0;
    logic                   lock = 1'b0;
    logic                   w_en = 1'b0;
    logic [CHAR_W-1:0]      w_char = '0;
    logic                   rd_en = 1'b0;
    logic [NRD*IDX_W-1:0]   rd_ord = '0;
    logic                   w_ready;
    logic [LEN_W-1:0]       len;
    logic                   full;
    logic                   err_ovf;
    logic                   rd_valid;
    logic [NRD*CHAR_W-1:0]  rd_char;
    logic [NRD*IDX_W-1:0]   rd_next;
    logic [NRD-1:0]         rd_wrap;
    logic [NRD-1:0]         rd_oor;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: table contents as a queue, sticky error, expected lane outputs.
    logic [CHAR_W-1:0] m_q [$];
    logic              m_err;
    logic [CHAR_W-1:0] e_ch   [NRD];
    int                e_nxt  [NRD];
    logic              e_wrap [NRD];
    logic              e_oor  [NRD];
    logic              e_valid;

    charset_table_mp #(.NUM_RD(NRD)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .lock(lock),
        .w_en(w_en), .w_char(w_char), .w_ready(w_ready), .len(len),
        .full(full), .err_ovf(err_ovf), .rd_en(rd_en), .rd_ord(rd_ord),
        .rd_valid(rd_valid), .rd_char(rd_char), .rd_next(rd_next),
        .rd_wrap(rd_wrap), .rd_oor(rd_oor)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_q.delete();
        m_err   = 1'b0;
        e_valid = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            e_ch[i] = '0; e_nxt[i] = 0; e_wrap[i] = 1'b1; e_oor[i] = 1'b0;
        end
    endtask

    task automatic set_ords(input int a, input int b, input int c, input int d);
        rd_ord[0*IDX_W +: IDX_W] = a[IDX_W-1:0];
        rd_ord[1*IDX_W +: IDX_W] = b[IDX_W-1:0];
        rd_ord[2*IDX_W +: IDX_W] = c[IDX_W-1:0];
        rd_ord[3*IDX_W +: IDX_W] = d[IDX_W-1:0];
    endtask

    // Advance one clock: predict read results from the pre-edge table, apply host ops to the model.
    task automatic tick();
        int n;
        int ord;
        n = m_q.size();
        e_valid = rd_en;
        if (rd_en) begin
            for (int i = 0; i < NRD; i++) begin
                ord = int'(rd_ord[i*IDX_W +: IDX_W]);
                e_oor[i]  = (ord >= n);
                e_wrap[i] = (ord + 1 >= n);
                e_nxt[i]  = (ord + 1 >= n) ? 0 : ord + 1;
                e_ch[i]   = (ord < n) ? m_q[ord] : '0;
            end
        end
        if (clear) begin
            m_q.delete();
            m_err = 1'b0;
        end else if (w_en) begin
            if (!lock && n < DEPTH) m_q.push_back(w_char);
            else m_err = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        reset_n = 1'b0;
        #12;
        n_checks++; if (len !== '0) begin n_fail++; $display("FAIL reset_len got %0d exp 0", len); end
        n_checks++; if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err_ovf); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", rd_valid); end
        n_checks++; if (rd_wrap !== 4'hF) begin n_fail++; $display("FAIL reset_wrap got %h exp f", rd_wrap); end
        n_checks++; if (rd_char !== '0 || rd_next !== '0 || rd_oor !== '0) begin
            n_fail++; $display("FAIL reset_data got char %h next %h oor %h exp 0", rd_char, rd_next, rd_oor); end
        n_checks++; if (w_ready !== 1'b1 || full !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready got w_ready %b full %b exp 1 0", w_ready, full); end
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_basic_read();
        logic [NRD*CHAR_W-1:0] held;
        w_en = 1'b1;
        w_char = 7'h61; tick();
        w_char = 7'h62; tick();
        w_char = 7'h63; tick();
        w_en = 1'b0;
        n_checks++; if (len !== 7'd3) begin n_fail++; $display("FAIL basic_len got %0d exp 3", len); end
        rd_en = 1'b1; set_ords(0, 1, 2, 3); tick();
        n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b exp 1", rd_valid); end
        n_checks++; if (rd_char !== {7'h00, 7'h63, 7'h62, 7'h61}) begin
            n_fail++; $display("FAIL basic_char got %h exp %h", rd_char, {7'h00, 7'h63, 7'h62, 7'h61}); end
        n_checks++; if (rd_next !== {6'd0, 6'd0, 6'd2, 6'd1}) begin
            n_fail++; $display("FAIL basic_next got %h exp %h", rd_next, {6'd0, 6'd0, 6'd2, 6'd1}); end
        n_checks++; if (rd_wrap !== 4'b1100 || rd_oor !== 4'b1000) begin
            n_fail++; $display("FAIL basic_flags got wrap %b oor %b exp 1100 1000", rd_wrap, rd_oor); end
        held = rd_char;
        rd_en = 1'b0; set_ords(3, 3, 3, 3); tick();
        n_checks++; if (rd_valid !== 1'b0 || rd_char !== held) begin
            n_fail++; $display("FAIL basic_hold got valid %b char %h exp 0 %h", rd_valid, rd_char, held); end
    endtask

    task automatic test_fill_overflow();
        logic [CHAR_W-1:0] fill [DEPTH];
        clear = 1'b1; tick(); clear = 1'b0;
        w_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            fill[i] = CHAR_W'($urandom_range(1, 127));
            w_char = fill[i];
            tick();
        end
        w_en = 1'b0; #1;
        n_checks++; if (full !== 1'b1 || w_ready !== 1'b0 || len !== 7'd64) begin
            n_fail++; $display("FAIL fill_full got full %b w_ready %b len %0d exp 1 0 64", full, w_ready, len); end
        w_en = 1'b1; w_char = 7'h55; tick(); w_en = 1'b0;
        n_checks++; if (err_ovf !== 1'b1 || len !== 7'd64) begin
            n_fail++; $display("FAIL fill_ovf got err %b len %0d exp 1 64", err_ovf, len); end
        rd_en = 1'b1; set_ords(0, 63, 62, 5); tick(); rd_en = 1'b0;
        n_checks++; if (rd_char !== {fill[5], fill[62], fill[63], fill[0]}) begin
            n_fail++; $display("FAIL fill_char got %h exp %h", rd_char, {fill[5], fill[62], fill[63], fill[0]}); end
        n_checks++; if (rd_next !== {6'd6, 6'd63, 6'd0, 6'd1} || rd_wrap !== 4'b0010 || rd_oor !== 4'b0000) begin
            n_fail++; $display("FAIL fill_flags got next %h wrap %b oor %b exp %h 0010 0000",
                               rd_next, rd_wrap, rd_oor, {6'd6, 6'd63, 6'd0, 6'd1}); end
        clear = 1'b1; tick(); clear = 1'b0;
        n_checks++; if (len !== '0 || err_ovf !== 1'b0 || full !== 1'b0) begin
            n_fail++; $display("FAIL fill_clear got len %0d err %b full %b exp 0 0 0", len, err_ovf, full); end
    endtask

    task automatic test_lock();
        lock = 1'b1; w_en = 1'b1; w_char = 7'h41; #1;
        n_checks++; if (w_ready !== 1'b0) begin n_fail++; $display("FAIL lock_ready got %b exp 0", w_ready); end
        tick();
        n_checks++; if (len !== '0 || err_ovf !== 1'b1) begin
            n_fail++; $display("FAIL lock_reject got len %0d err %b exp 0 1", len, err_ovf); end
        lock = 1'b0; tick(); w_en = 1'b0;
        n_checks++; if (len !== 7'd1) begin n_fail++; $display("FAIL lock_write got len %0d exp 1", len); end
        rd_en = 1'b1; set_ords(0, 0, 0, 0); tick(); rd_en = 1'b0;
        n_checks++; if (rd_char !== {4{7'h41}} || rd_next !== '0 || rd_wrap !== 4'hF || rd_oor !== 4'h0) begin
            n_fail++; $display("FAIL lock_read got char %h next %h wrap %b oor %b exp %h 0 1111 0000",
                               rd_char, rd_next, rd_wrap, rd_oor, {4{7'h41}}); end
    endtask

    task automatic test_write_read_same_cycle();
        clear = 1'b1; tick(); clear = 1'b0;
        w_en = 1'b1; w_char = 7'h10; tick(); w_char = 7'h11; tick();
        w_char = 7'h7A; rd_en = 1'b1; set_ords(2, 2, 2, 2); tick(); w_en = 1'b0;
        n_checks++; if (rd_oor !== 4'hF || rd_char !== '0 || len !== 7'd3) begin
            n_fail++; $display("FAIL same_cycle_oor got oor %b char %h len %0d exp 1111 0 3", rd_oor, rd_char, len); end
        tick(); rd_en = 1'b0;
        n_checks++; if (rd_char !== {4{7'h7A}} || rd_oor !== 4'h0 || rd_wrap !== 4'hF || rd_next !== '0) begin
            n_fail++; $display("FAIL same_cycle_next got char %h oor %b wrap %b next %h exp %h 0000 1111 0",
                               rd_char, rd_oor, rd_wrap, rd_next, {4{7'h7A}}); end
    endtask

    task automatic test_clear_priority();
        clear = 1'b1; lock = 1'b1; w_en = 1'b1; w_char = 7'h55; tick();
        clear = 1'b0; lock = 1'b0; w_en = 1'b0;
        n_checks++; if (len !== '0 || err_ovf !== 1'b0) begin
            n_fail++; $display("FAIL clear_prio got len %0d err %b exp 0 0", len, err_ovf); end
        rd_en = 1'b1; set_ords(0, 1, 2, 3); tick(); rd_en = 1'b0;
        n_checks++; if (rd_oor !== 4'hF || rd_wrap !== 4'hF || rd_char !== '0 || rd_next !== '0) begin
            n_fail++; $display("FAIL empty_read got oor %b wrap %b char %h next %h exp 1111 1111 0 0",
                               rd_oor, rd_wrap, rd_char, rd_next); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            clear  = ($urandom_range(0, 99) < 1);
            lock   = ($urandom_range(0, 99) < 20);
            w_en   = ($urandom_range(0, 99) < 55);
            w_char = CHAR_W'($urandom);
            rd_en  = ($urandom_range(0, 99) < 70);
            for (int i = 0; i < NRD; i++) rd_ord[i*IDX_W +: IDX_W] = IDX_W'($urandom_range(0, DEPTH - 1));
            tick();
            n_checks++;
            if (int'(len) != m_q.size() || err_ovf !== m_err || full !== (m_q.size() == DEPTH)
                || w_ready !== (m_q.size() < DEPTH && !lock) || rd_valid !== e_valid) begin
                n_fail++;
                $display("FAIL rand_ctrl cycle %0d got len %0d err %b full %b rdy %b vld %b exp len %0d err %b vld %b",
                         c, len, err_ovf, full, w_ready, rd_valid, m_q.size(), m_err, e_valid);
            end
            for (int i = 0; i < NRD; i++) begin
                n_checks++;
                if (rd_char[i*CHAR_W +: CHAR_W] !== e_ch[i] || int'(rd_next[i*IDX_W +: IDX_W]) != e_nxt[i]
                    || rd_wrap[i] !== e_wrap[i] || rd_oor[i] !== e_oor[i]) begin
                    n_fail++;
                    $display("FAIL rand_lane%0d cycle %0d got ch %h nxt %0d wrap %b oor %b exp ch %h nxt %0d wrap %b oor %b",
                             i, c, rd_char[i*CHAR_W +: CHAR_W], rd_next[i*IDX_W +: IDX_W], rd_wrap[i], rd_oor[i],
                             e_ch[i], e_nxt[i], e_wrap[i], e_oor[i]);
                end
            end
        end
        clear = 1'b0; lock = 1'b0; w_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_async_reset();
        w_en = 1'b1; w_char = 7'h33; tick(); w_en = 1'b0;
        rd_en = 1'b1; set_ords(0, 0, 0, 0); tick();
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (rd_valid !== 1'b0 || len !== '0 || rd_wrap !== 4'hF) begin
            n_fail++; $display("FAIL async_reset got valid %b len %0d wrap %b exp 0 0 1111", rd_valid, len, rd_wrap); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
        tick(); rd_en = 1'b0;
        n_checks++; if (rd_oor[0] !== 1'b1 || rd_valid !== 1'b1 || rd_char[CHAR_W-1:0] !== '0) begin
            n_fail++; $display("FAIL post_reset_read got oor %b valid %b char %h exp 1 1 0",
                               rd_oor[0], rd_valid, rd_char[CHAR_W-1:0]); end
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_fill_overflow();
        test_lock();
        test_write_read_same_cycle();
        test_clear_priority();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
